// File: rtl/ifio_mux.sv
// ifio_mux: NCH-channel FIFO-buffered round-robin beat multiplexer onto one registered output
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready/in_last   : per-channel handshake and end-of-packet (NCH bits each)
//   in_data                     : channel c at bits [c*DW +: DW]
//   out_valid/out_ready         : output handshake
//   out_data/out_last/out_chan  : output beat, end-of-packet, source channel
//   Define IFIO_MUX_LOCK_EN to keep the grant on one channel until its last beat is loaded.
module ifio_mux #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int OW   = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [CW-1:0]     out_chan
);
  logic [DW:0]   mem_q [NCH][DEPTH];
  logic [AW-1:0] wp_q [NCH], wp_d [NCH], rp_q [NCH], rp_d [NCH];
  logic [OW-1:0] cnt_q [NCH], cnt_d [NCH];
  logic [NCH-1:0] wr, rd;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_chan_q, out_chan_d, rr_q, rr_d, gnt, idx, nxt;
  logic          load_en, found, pop;
  logic [DW:0]   head;
`ifdef IFIO_MUX_LOCK_EN
  logic          lock_q, lock_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;
`endif
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  always_comb begin
    load_en = !out_valid_q || out_ready;
    found = 1'b0;
    gnt = '0;
    idx = '0;
    // first non-empty channel at or after rr_q, wrapping
    for (int k = 0; k < NCH; k++) begin
      idx = CW'((int'(rr_q) + k) % NCH);
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        gnt = idx;
      end
    end
`ifdef IFIO_MUX_LOCK_EN
    // a locked channel owns the output even when empty (bubble)
    if (lock_q) begin
      found = cnt_q[lock_ch_q] != '0;
      gnt = lock_ch_q;
    end
`endif
    pop = load_en && found;
    head = mem_q[gnt][rp_q[gnt]];
    nxt = (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
    out_valid_d = load_en ? found : out_valid_q;
    out_data_d = pop ? head[DW-1:0] : out_data_q;
    out_last_d = pop ? head[DW] : out_last_q;
    out_chan_d = pop ? gnt : out_chan_q;
`ifdef IFIO_MUX_LOCK_EN
    rr_d = (pop && head[DW]) ? nxt : rr_q;
    lock_d = pop ? !head[DW] : lock_q;
    lock_ch_d = pop ? gnt : lock_ch_q;
`else
    rr_d = pop ? nxt : rr_q;
`endif
    for (int c = 0; c < NCH; c++) begin
      in_ready[c] = cnt_q[c] != OW'(DEPTH);
      wr[c] = in_valid[c] && in_ready[c];
      rd[c] = pop && gnt == CW'(c);
      wp_d[c] = wr[c] ? wp_q[c] + 1'b1 : wp_q[c];
      rp_d[c] = rd[c] ? rp_q[c] + 1'b1 : rp_q[c];
      cnt_d[c] = cnt_q[c] + OW'(wr[c]) - OW'(rd[c]);
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (wr[c]) mem_q[c][wp_q[c]] <= {in_last[c], in_data[c*DW +: DW]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_chan_q <= '0;
      rr_q <= '0;
`ifdef IFIO_MUX_LOCK_EN
      lock_q <= 1'b0;
      lock_ch_q <= '0;
`endif
      for (int c = 0; c < NCH; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_chan_q <= out_chan_d;
      rr_q <= rr_d;
`ifdef IFIO_MUX_LOCK_EN
      lock_q <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
      for (int c = 0; c < NCH; c++) begin
        wp_q[c] <= wp_d[c];
        rp_q[c] <= rp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
endmodule

// File: tb/tb_ifio_mux.sv
// tb_ifio_mux: directed and random stimulus for ifio_mux checked against a queue-based model
module tb_ifio_mux;
  localparam int NCH = 4, DW = 32, DEPTH = 4, CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [NCH*DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0, out_last;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_chan;
  int n_assert = 0, n_fail = 0;
  logic [DW:0] q [NCH][$];
  bit m_ov, m_ol, m_lock;
  logic [DW-1:0] m_od;
  int m_oc, m_rr, m_lch;
  ifio_mux #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_chan(out_chan)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NCH-1:0] m_ready();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = q[c].size() < DEPTH;
    return r;
  endfunction
  task automatic check_all(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_ov));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(m_ready()));
    if (m_ov) begin
      check({tag, "_data"}, 64'(out_data), 64'(m_od));
      check({tag, "_last"}, 64'(out_last), 64'(m_ol));
      check({tag, "_chan"}, 64'(out_chan), 64'(m_oc));
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0; m_rr = 0; m_lock = 0; m_lch = 0;
  endtask
  task automatic step(input string tag);
    logic [NCH-1:0] acc;
    logic [DW:0] b;
    bit f;
    int g;
    @(posedge clk);
    acc = in_valid & m_ready();
    if (!m_ov || out_ready) begin
      f = 0;
      g = 0;
      if (m_lock) begin
        f = q[m_lch].size() > 0;
        g = m_lch;
      end else begin
        for (int k = 0; k < NCH; k++)
          if (!f && q[(m_rr + k) % NCH].size() > 0) begin
            f = 1;
            g = (m_rr + k) % NCH;
          end
      end
      m_ov = f;
      if (f) begin
        b = q[g].pop_front();
        m_od = b[DW-1:0];
        m_ol = b[DW];
        m_oc = g;
`ifdef IFIO_MUX_LOCK_EN
        m_lock = !b[DW];
        m_lch = g;
        if (b[DW]) m_rr = (g + 1) % NCH;
`else
        m_rr = (g + 1) % NCH;
`endif
      end
    end
    for (int c = 0; c < NCH; c++)
      if (acc[c]) q[c].push_back({in_last[c], in_data[c*DW +: DW]});
    #1;
    check_all(tag);
  endtask
  task automatic set_beat(input int c, input logic [DW-1:0] d, input logic l);
    in_valid[c] = 1'b1;
    in_data[c*DW +: DW] = d;
    in_last[c] = l;
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_data"}, 64'(out_data), 64'd0);
    check({tag, "_rst_last"}, 64'(out_last), 64'd0);
    check({tag, "_rst_chan"}, 64'(out_chan), 64'd0);
    check({tag, "_rst_ready"}, 64'(in_ready), 64'hF);
    in_valid = '0;
    in_last = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    model_clear();
    do_reset("init");
    // single beat on ch2
    out_ready = 1'b1;
    set_beat(2, 32'hA5, 1'b1);
    step("r030_wr");
    in_valid = '0;
    step("r030_out");
    check("r030_valid_k", 64'(out_valid), 64'd1);
    check("r030_data_k", 64'(out_data), 64'hA5);
    check("r030_chan_k", 64'(out_chan), 64'd2);
    step("r030_idle");
    // one beat on every channel emerges in channel order
    do_reset("r031");
    for (int c = 0; c < NCH; c++) set_beat(c, 32'h100 + c, 1'b1);
    step("r031_wr");
    in_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      step("r031_out");
      check("r031_chan_k", 64'(out_chan), 64'(k));
    end
    step("r031_empty");
    check("r031_empty_k", 64'(out_valid), 64'd0);
    // fill ch1 with output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_beat(1, 32'h200 + k, 1'b1);
      step("r032_fill");
    end
    check("r032_full_k", 64'(in_ready[1]), 64'd0);
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) step("r032_drain");
    // out_ready toggling during a random stream
    for (int k = 0; k < 40; k++) begin
      out_ready = k[0];
      for (int c = 0; c < NCH; c++) begin
        in_valid[c] = 1'($urandom_range(0, 1));
        in_data[c*DW +: DW] = $urandom;
        in_last[c] = 1'($urandom_range(0, 1));
      end
      step("r033_toggle");
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) step("r033_drain");
    // ch0 3-beat packet against continuously valid ch1
    do_reset("r034");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_beat(0, 32'h300 + k, k == 2);
      set_beat(1, 32'h400 + k, 1'b1);
      step("r034_pkt");
    end
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_beat(1, 32'h410 + k, 1'b1);
      step("r034_ch1");
    end
    in_valid = '0;
    for (int k = 0; k < 10; k++) step("r034_drain");
    // reset with beats buffered mid-packet
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_beat(3, 32'h500 + k, 1'b0);
      step("r035_fill");
    end
    in_valid = '0;
    do_reset("r035");
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step("r035_after");
    check("r035_no_stale_k", 64'(out_valid), 64'd0);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        in_valid[c] = ($urandom_range(0, 2) == 0);
        in_data[c*DW +: DW] = $urandom;
        in_last[c] = ($urandom_range(0, 2) == 0);
      end
      step("rand");
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) step("rand_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
